// File: rtl/bsg_dff_skid_reset_n.sv
// Two-entry ready/valid register slice with async active-low reset; all outputs are registered.
// Optional stall counter output is enabled by defining BSG_SKID_STALL_CNT_EN.
module bsg_dff_skid_reset_n #(
  parameter int width_p     = 64,
  parameter int stall_cnt_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
`ifdef BSG_SKID_STALL_CNT_EN
  ,
  output logic [stall_cnt_p-1:0] stall_cnt_o
`endif
);

  // Handshake: a word enters when v_i & ready_o at posedge and leaves when v_o & ready_i at
  // posedge. ready_o and v_o come straight from state flops, so neither side sees a
  // combinational path through this slice.

  // State encoding is {main_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e             state_r, state_n;
  logic [1:0]         state_bits;
  logic               main_load, main_from_skid, skid_load;
  logic [width_p-1:0] main_r, skid_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= EMPTY;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n        = state_r;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (v_i) begin
          state_n   = ONE;
          main_load = 1'b1;
        end
      end
      ONE: begin
        if (v_i && ready_i) begin
          main_load = 1'b1;
        end else if (v_i) begin
          state_n   = FULL;
          skid_load = 1'b1;
        end else if (ready_i) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        // ready_o is low here, so v_i/data_i are not looked at.
        if (ready_i) begin
          state_n        = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      main_r <= '0;
      skid_r <= '0;
    end else begin
      if (main_load)           main_r <= data_i;
      else if (main_from_skid) main_r <= skid_r;
      if (skid_load)           skid_r <= data_i;
    end
  end

  assign state_bits = state_r;
  assign v_o        = state_bits[1];
  assign ready_o    = ~state_bits[0];
  assign data_o     = main_r;

`ifdef BSG_SKID_STALL_CNT_EN
  logic [stall_cnt_p-1:0] stall_cnt_r;

  // Saturating count of cycles where the consumer held off valid data.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_r <= '0;
    end else if (v_o && !ready_i && !(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + stall_cnt_p'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_bsg_dff_skid_reset_n.sv
// Bench for bsg_dff_skid_reset_n: directed scenarios plus a random v_i/ready_i run scored
// against a two-deep FIFO model of the slice.
module tb_bsg_dff_skid_reset_n;

  localparam int W = 64;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         v_i;
  logic [W-1:0] data_i;
  logic         ready_o;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         ready_i;
`ifdef BSG_SKID_STALL_CNT_EN
  logic [3:0]   stall_cnt_o;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  bsg_dff_skid_reset_n #(.width_p(W), .stall_cnt_p(4)) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .ready_i    (ready_i)
`ifdef BSG_SKID_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // scoreboard: model of the slice contents as an ordered queue of at most two words,
  // plus the last word sent (the output register keeps it once the slice empties)
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out = '0;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      exp_q.delete();
      last_out = '0;
    end else begin
      automatic bit accept = v_i && (exp_q.size() < 2);
      if (exp_q.size() > 0 && ready_i) last_out = exp_q.pop_front();
      if (accept) exp_q.push_back(data_i);
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // compare process: every cycle, away from the active edge
  always @(negedge clk_i) begin
    check("model_v_o", W'(v_o), W'(exp_q.size() > 0));
    check("model_ready_o", W'(ready_o), W'(exp_q.size() < 2));
    check("model_data_o", data_o, (exp_q.size() > 0) ? exp_q[0] : last_out);
  end

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    v_i     = v;
    data_i  = d;
    ready_i = r;
    step();
  endtask

  initial begin
    reset_n_i = 1'b0;
    v_i       = 1'b1;
    data_i    = '1;
    ready_i   = 1'b0;

    // reset with producer pushing all-ones
    #12;
    check("rst_v_o", W'(v_o), W'(0));
    check("rst_data_o", data_o, W'(0));
    check("rst_ready_o", W'(ready_o), W'(1));
    reset_n_i = 1'b1;
    step();
    check("first_accept_data", data_o, {W{1'b1}});
    check("first_accept_v", W'(v_o), W'(1));

    // streaming at full throughput
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, W'(i), 1'b1);
      check("stream_data", data_o, W'(i));
      check("stream_ready", W'(ready_o), W'(1));
    end
    drive(1'b0, '0, 1'b1);
    check("stream_empty_v", W'(v_o), W'(0));

    // stall fill: A held, B skidded, C refused
    drive(1'b1, W'(64'hA), 1'b0);
    drive(1'b1, W'(64'hB), 1'b0);
    check("fill_ready", W'(ready_o), W'(0));
    check("fill_data", data_o, W'(64'hA));
    drive(1'b1, W'(64'hC), 1'b0);
    check("fill_hold_data", data_o, W'(64'hA));
    check("fill_hold_ready", W'(ready_o), W'(0));
    drive(1'b0, '0, 1'b1);
    check("fill_out_b", data_o, W'(64'hB));
    drive(1'b0, '0, 1'b1);
    check("fill_empty_v", W'(v_o), W'(0));
    check("fill_last_data", data_o, W'(64'hB));

    // drain from FULL holding 1/2
    drive(1'b1, W'(1), 1'b0);
    drive(1'b1, W'(2), 1'b0);
    v_i = 1'b0;
    ready_i = 1'b1;
    check("drain_first", data_o, W'(1));
    step();
    check("drain_second", data_o, W'(2));
    check("drain_second_v", W'(v_o), W'(1));
    step();
    check("drain_done_v", W'(v_o), W'(0));
    check("drain_done_ready", W'(ready_o), W'(1));

    // async reset pulse while FULL
    drive(1'b1, W'(3), 1'b0);
    drive(1'b1, W'(4), 1'b0);
    v_i = 1'b0;
    #1 reset_n_i = 1'b0;
    #1;
    check("async_v_o", W'(v_o), W'(0));
    check("async_ready_o", W'(ready_o), W'(1));
    check("async_data_o", data_o, W'(0));
    reset_n_i = 1'b1;
    step();
    check("async_lost_v", W'(v_o), W'(0));

`ifdef BSG_SKID_STALL_CNT_EN
    drive(1'b1, W'(5), 1'b0);
    v_i = 1'b0;
    repeat (20) step();
    check("stall_sat", W'(stall_cnt_o), W'(4'hF));
    #1 reset_n_i = 1'b0;
    #1;
    check("stall_rst", W'(stall_cnt_o), W'(0));
    reset_n_i = 1'b1;
    step();
`endif

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      v_i     = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      data_i  = {$urandom, $urandom};
      step();
    end

    v_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) step();
    check("final_empty", W'(v_o), W'(0));

    // final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
